// File: rtl/hash_pkg.sv
// Shared widths, FSM encoding and helpers for the key scheduler slice.
// The hash is carried as three concatenated fields {h28,h24,h5}.
package hash_pkg;
  localparam int FIFOWIDTH     = 128;
  localparam int H28_W         = 28;
  localparam int H24_W         = 24;
  localparam int H5_W          = 5;
  localparam int KEYHASH_WIDTH = H28_W + H24_W + H5_W;
  localparam int CNT_W         = 16;
  localparam int LEN_W         = 8;
  localparam int WORDS_W       = 5;
  localparam int WORD_SHIFT    = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;

  typedef struct packed {
    logic [H28_W-1:0] h28;
    logic [H24_W-1:0] h24;
    logic [H5_W-1:0]  h5;
  } key_hash_t;

  // Byte length to 16-byte word count, rounded up; 255 bytes gives 16 words.
  function automatic logic [WORDS_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'((1 << WORD_SHIFT) - 1);
    return WORDS_W'(sum >> WORD_SHIFT);
  endfunction
endpackage

// File: rtl/hash_key_sched_if.sv
// Bundle of FIFO, core and result-FIFO signals around the key scheduler.
// master is the scheduler side; slave is the surrounding environment.
interface hash_key_sched_if;
  import hash_pkg::*;

  logic                     iRdKeyLenEmpty;
  logic [LEN_W-1:0]         iKeyLen;
  logic                     oRdKeyLenFifo_en;
  logic                     iRdKeyEmpty;
  logic [FIFOWIDTH-1:0]     iKey;
  logic                     oRdKeyFifo_en;
  logic                     oCoreStart;
  logic [LEN_W-1:0]         oCoreLen;
  logic                     oCoreValid;
  logic [FIFOWIDTH-1:0]     oCoreData;
  logic                     oCoreLast;
  logic                     iCoreReady;
  logic                     iCoreDone;
  logic [KEYHASH_WIDTH-1:0] iCoreHash;
  logic                     iWrHashFull;
  logic                     oWrHashFifo_en;
  logic [KEYHASH_WIDTH-1:0] oKeyHash;
  logic                     oBusy;
  logic [CNT_W-1:0]         oKeyCnt;
  logic                     oErrZeroLen;
  logic                     oErrTimeout;

  modport master (
    input  iRdKeyLenEmpty, iKeyLen, iRdKeyEmpty, iKey, iCoreReady,
           iCoreDone, iCoreHash, iWrHashFull,
    output oRdKeyLenFifo_en, oRdKeyFifo_en, oCoreStart, oCoreLen, oCoreValid,
           oCoreData, oCoreLast, oWrHashFifo_en, oKeyHash, oBusy, oKeyCnt,
           oErrZeroLen, oErrTimeout
  );

  modport slave (
    output iRdKeyLenEmpty, iKeyLen, iRdKeyEmpty, iKey, iCoreReady,
           iCoreDone, iCoreHash, iWrHashFull,
    input  oRdKeyLenFifo_en, oRdKeyFifo_en, oCoreStart, oCoreLen, oCoreValid,
           oCoreData, oCoreLast, oWrHashFifo_en, oKeyHash, oBusy, oKeyCnt,
           oErrZeroLen, oErrTimeout
  );
endinterface

// File: rtl/hash_sched_timeout.sv
// Loadable down-counter guarding the wait for the hash core.
// Loaded with TIMEOUT-1 on entry; expires on the TIMEOUT-th counted cycle.
module hash_sched_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/hash_key_sched.sv
// Sequences one key from the length/key FIFOs through the hash core and
// writes its hash to the result FIFO; survives zero-length keys and core hangs.
module hash_key_sched
  import hash_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  hash_key_sched_if.master bus
);
  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [LEN_W-1:0]   r_core_len;
  logic [WORDS_W-1:0] r_remaining;
  key_hash_t          r_key_hash;
  logic [CNT_W-1:0]   r_key_cnt;
  logic               r_err_zero;
  logic               r_err_timeout;
  logic               w_xfer;
  logic               w_last_xfer;
  logic               w_expired;
  logic               w_wait_done;
  logic               w_wait_abort;
  logic               w_write;

  hash_sched_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_last_xfer),
    .i_en      (r_state == S_WAIT),
    .o_expired (w_expired)
  );

  // NOTE: every signal written here gets a default first, so no case path infers a latch.
  always_comb begin
    w_next                = r_state;
    w_xfer                = 1'b0;
    w_last_xfer           = 1'b0;
    w_wait_done           = 1'b0;
    w_wait_abort          = 1'b0;
    w_write               = 1'b0;
    bus.oRdKeyLenFifo_en  = 1'b0;
    bus.oRdKeyFifo_en     = 1'b0;
    bus.oCoreStart        = 1'b0;
    bus.oCoreValid        = 1'b0;
    bus.oCoreData         = '0;
    bus.oCoreLast         = 1'b0;
    bus.oWrHashFifo_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.iRdKeyLenEmpty) w_next = S_LEN;
      end
      S_LEN: begin
        bus.oRdKeyLenFifo_en = 1'b1;
        w_next = (bus.iKeyLen == '0) ? S_IDLE : S_START;
      end
      S_START: begin
        bus.oCoreStart = 1'b1;
        w_next         = S_FEED;
      end
      S_FEED: begin
        w_xfer            = !bus.iRdKeyEmpty && bus.iCoreReady;
        w_last_xfer       = w_xfer && (r_remaining == WORDS_W'(1));
        bus.oRdKeyFifo_en = w_xfer;
        bus.oCoreValid    = w_xfer;
        bus.oCoreData     = bus.iKey;
        bus.oCoreLast     = w_last_xfer;
        if (w_last_xfer) w_next = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the expiring cycle still wins over the abort.
        w_wait_done  = bus.iCoreDone;
        w_wait_abort = !bus.iCoreDone && w_expired;
        if (w_wait_done)       w_next = S_WRITE;
        else if (w_wait_abort) w_next = S_IDLE;
      end
      S_WRITE: begin
        w_write            = !bus.iWrHashFull;
        bus.oWrHashFifo_en = w_write;
        if (w_write) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_core_len    <= '0;
      r_remaining   <= '0;
      r_key_hash    <= '0;
      r_key_cnt     <= '0;
      r_err_zero    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LEN) begin
        r_core_len  <= bus.iKeyLen;
        r_remaining <= len_to_words(bus.iKeyLen);
        if (bus.iKeyLen == '0) r_err_zero <= 1'b1;
      end
      if (w_xfer)       r_remaining   <= r_remaining - WORDS_W'(1);
      if (w_wait_done)  r_key_hash    <= bus.iCoreHash;
      if (w_wait_abort) r_err_timeout <= 1'b1;
      if (w_write)      r_key_cnt     <= r_key_cnt + CNT_W'(1);
    end
  end

  assign bus.oCoreLen    = r_core_len;
  assign bus.oKeyHash    = r_key_hash;
  assign bus.oKeyCnt     = r_key_cnt;
  assign bus.oErrZeroLen = r_err_zero;
  assign bus.oErrTimeout = r_err_timeout;
  assign bus.oBusy       = (r_state != S_IDLE);
endmodule

// File: doc/hash_key_sched.md
Name: hash_key_sched

Overview:
Sequencer between the upstream key/key-length FIFOs and the hash core, and between the hash core and the downstream hash-result FIFO.
- Pops one key length, then streams exactly ceil(len/16) 128-bit key words into the core.
- Waits for the core's three-part hash (28+24+5 = 57 bits) and writes it to the result FIFO.
- Handles zero-length keys and core hangs without stalling the pipeline.

Parameters:
FIFOWIDTH, 128, key word width in bits (16 bytes per word)
KEYHASH_WIDTH, 57, concatenated hash width {h28,h24,h5}
TIMEOUT, 1024, max cycles in WAIT before abort
CNT_W, 16, width of processed-key counter

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
iRdKeyLenEmpty  in  1  key-length FIFO empty (FWFT: iKeyLen valid while low)
iKeyLen  in  8  key length in bytes
oRdKeyLenFifo_en  out  1  pop key-length FIFO
iRdKeyEmpty  in  1  key FIFO empty (FWFT)
iKey  in  FIFOWIDTH  key word
oRdKeyFifo_en  out  1  pop key FIFO
oCoreStart  out  1  one-cycle pulse; begins a new key in the core
oCoreLen  out  8  latched key length, stable from START until IDLE
oCoreValid  out  1  oCoreData valid this cycle
oCoreData  out  FIFOWIDTH  key word to core (pass-through of iKey)
oCoreLast  out  1  marks the final word of the key
iCoreReady  in  1  core accepts a word this cycle
iCoreDone  in  1  one-cycle pulse; iCoreHash valid
iCoreHash  in  KEYHASH_WIDTH  hash result
iWrHashFull  in  1  result FIFO full
oWrHashFifo_en  out  1  write result FIFO
oKeyHash  out  KEYHASH_WIDTH  result data, registered
oBusy  out  1  state != IDLE
oKeyCnt  out  CNT_W  keys successfully written (wraps)
oErrZeroLen  out  1  sticky; zero-length key seen
oErrTimeout  out  1  sticky; core timeout seen

Behaviour:
- Reset (rst=0, async): state=IDLE; all registered outputs 0 (oCoreLen, oKeyHash, oKeyCnt, error flags, word counter, timeout counter). Combinational outputs are 0 in IDLE.
- FSM states: IDLE, LEN, START, FEED, WAIT, WRITE.
- IDLE: if !iRdKeyLenEmpty go to LEN.
- LEN: oRdKeyLenFifo_en=1 for exactly one cycle. Latch len=iKeyLen and words=(len+15)>>4, a 5-bit value in the range 1..16.
  - len==0: set oErrZeroLen, pop no key words, write no result, return to IDLE.
  - Otherwise go to START.
- START: oCoreStart=1 for one cycle, then FEED.
- FEED: xfer = !iRdKeyEmpty & iCoreReady.
  - oRdKeyFifo_en = oCoreValid = xfer, combinational.
  - oCoreData = iKey.
  - oCoreLast = xfer & (remaining==1).
  - On xfer, remaining decrements. After the last xfer go to WAIT with the timeout counter cleared.
  - Empty or !ready stalls with no pop and no valid.
- WAIT: count cycles.
  - iCoreDone: latch oKeyHash=iCoreHash, go to WRITE.
  - Counter reaches TIMEOUT-1 with no done: set oErrTimeout, return to IDLE, no write.
  - iCoreDone in any state other than WAIT is ignored.
- WRITE: oWrHashFifo_en = !iWrHashFull, combinational. On the write cycle, oKeyCnt+1 and go to IDLE. Full holds in WRITE indefinitely; no timeout applies.
- Latency, no stalls: LEN→START→first word = 2 cycles after the pop. Back-to-back keys pass through one IDLE cycle.
- iKeyLen is sampled only in LEN. Key words beyond ceil(len/16) are never popped, so they belong to the next key.
- oKeyCnt wraps 2^CNT_W-1 → 0.
- Reset mid-key abandons the key with no FIFO cleanup. Upstream FIFOs are reset by the same rst.

Decomposition:
- Shared package hash_pkg: FIFOWIDTH, KEYHASH_WIDTH, hash field widths 28/24/5, state encoding localparams, and the bytes-to-words constant (shift 4).
- One natural sub-module: hash_sched_timeout, a loadable down-counter with an expire flag, used in WAIT.

Test Plan:
- len=0x20, 2 words in key FIFO, core always ready, done 5 cycles after last → pops=2, oCoreLast on 2nd word, one write of iCoreHash, oKeyCnt=1.
- len=0x00 followed by len=0x01 → oErrZeroLen=1, no key pop for the first; second key pops 1 word and writes 1 result.
- len=0xFF with iCoreReady toggling 1/0 and key FIFO empty for 3 cycles mid-stream → exactly 16 pops, no valid during stalls, data order preserved.
- iWrHashFull=1 for 20 cycles at WRITE → oWrHashFifo_en=0 throughout; single write on release; next key not started until then.
- No iCoreDone with TIMEOUT=16 → oErrTimeout=1 after 16 WAIT cycles, no write, next queued key processed normally.
- rst to 0 during FEED of a 4-word key after 2 words → all outputs 0 immediately; after release the FSM is in IDLE and restarts on the next length entry.
